fetch_unit: RTL and testbench

Instruction-fetch stage for the 16-bit pipelined core. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It consumes `stall`, `flush` and the branch target produced by the hazard-detection/branch logic in ID, and produces the instruction and PC+2 that ID decodes next cycle.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the instruction-memory request handshake
// and the IF/ID pipeline register. Handles stall, branch flush and HALT freeze.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OPC  = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_pc_plus2,
  output logic        IF_ID_valid,
  output logic        halted
);

  typedef enum logic [1:0] {StReq, StBuf, StDrop, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic [15:0] accept_word;
  logic        accept;

  assign pc_plus2    = pc_q + 16'd2;
  assign accept_word = (state_q == StBuf) ? buf_q : imem_data;

  assign imem_req       = !rst && ((state_q == StReq) || (state_q == StDrop));
  assign imem_addr      = pc_q;
  assign IF_ID_instr    = instr_q;
  assign IF_ID_pc_plus2 = pp2_q;
  assign IF_ID_valid    = valid_q;
  assign halted         = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    instr_d  = instr_q;
    pp2_d    = pp2_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    accept   = 1'b0;

    if (flush) begin
      pc_d     = {branch_target[15:1], 1'b0};
      instr_d  = NOP_INSTR;
      pp2_d    = 16'h0000;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      // A request still in flight must have its response drained before refetching.
      if (((state_q == StReq) || (state_q == StDrop)) && !imem_valid) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_valid) begin
            if (stall) begin
              buf_d   = imem_data;
              state_d = StBuf;
            end else begin
              accept = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            pp2_d   = 16'h0000;
            valid_d = 1'b0;
          end
        end
        StBuf: begin
          if (!stall) begin
            accept = 1'b1;
          end
        end
        StDrop: begin
          if (imem_valid) begin
            state_d = StReq;
          end
          if (!stall) begin
            instr_d = NOP_INSTR;
            pp2_d   = 16'h0000;
            valid_d = 1'b0;
          end
        end
        StHalt: begin
        end
        default: begin
          state_d = StReq;
        end
      endcase

      if (accept) begin
        instr_d = accept_word;
        pp2_d   = pc_plus2;
        valid_d = 1'b1;
        if (accept_word[15:12] == HALT_OPC) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          pc_d    = pc_plus2;
          state_d = StReq;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReq;
      pc_q     <= RESET_PC;
      buf_q    <= NOP_INSTR;
      instr_q  <= NOP_INSTR;
      pp2_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      instr_q  <= instr_d;
      pp2_q    <= pp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the fetch/stall/miss-flush flow,
// then hand sequences for HALT, stall+flush, PC wrap and reset mid-miss.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc_plus2;
  logic        IF_ID_valid;
  logic        halted;
  logic        halt_en;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_valid     (imem_valid),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc_plus2 (IF_ID_pc_plus2),
    .IF_ID_valid    (IF_ID_valid),
    .halted         (halted)
  );

  function automatic logic [15:0] tag(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  // Address-tagged memory; a HALT word can be planted at 0x0040.
  assign imem_data = (halt_en && imem_addr == 16'h0040) ? 16'hF000 : tag(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] bt;
    logic        valid;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        iv;
    logic        halted;
  } vec_t;

  function automatic vec_t mk(input logic r, s, f, input logic [15:0] bt, input logic v,
                              input logic req, input logic [15:0] addr, instr, pp2,
                              input logic iv, h);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.bt = bt; t.valid = v;
    t.req = req; t.addr = addr; t.instr = instr; t.pp2 = pp2; t.iv = iv; t.halted = h;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, input logic [15:0] bt, input logic v);
    @(negedge clk);
    rst = r; stall = s; flush = f; branch_target = bt; imem_valid = v;
    #1;
  endtask

  vec_t tbl[18];

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 16'h0000;
    imem_valid = 1'b0; halt_en = 1'b0;

    //                r  s  f  bt        v   req addr      instr        pp2       iv h
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000,    16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0000, 16'h0000,    16'h0000, 0, 0);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0002, tag(16'h00), 16'h0002, 1, 0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0004, tag(16'h02), 16'h0004, 1, 0);
    tbl[4]  = mk(0, 0, 1, 16'h000F, 1,  1, 16'h0006, tag(16'h04), 16'h0006, 1, 0);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 1,  1, 16'h000E, 16'h0000,    16'h0000, 0, 0);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 1,  1, 16'h0010, tag(16'h0E), 16'h0010, 1, 0);
    tbl[7]  = mk(0, 1, 0, 16'h0000, 1,  0, 16'h0010, tag(16'h0E), 16'h0010, 1, 0);
    tbl[8]  = mk(0, 1, 0, 16'h0000, 0,  0, 16'h0010, tag(16'h0E), 16'h0010, 1, 0);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 0,  0, 16'h0010, tag(16'h0E), 16'h0010, 1, 0);
    tbl[10] = mk(0, 0, 1, 16'h0020, 1,  1, 16'h0012, tag(16'h10), 16'h0012, 1, 0);
    tbl[11] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0020, 16'h0000,    16'h0000, 0, 0);
    tbl[12] = mk(0, 0, 1, 16'h0100, 0,  1, 16'h0020, 16'h0000,    16'h0000, 0, 0);
    tbl[13] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0100, 16'h0000,    16'h0000, 0, 0);
    tbl[14] = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0100, 16'h0000,    16'h0000, 0, 0);
    tbl[15] = mk(0, 0, 0, 16'h0000, 1,  1, 16'h0100, 16'h0000,    16'h0000, 0, 0);
    tbl[16] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0102, tag(16'h100), 16'h0102, 1, 0);
    tbl[17] = mk(0, 0, 0, 16'h0000, 0,  1, 16'h0102, 16'h0000,    16'h0000, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].bt, tbl[i].valid);
      chk($sformatf("v%0d imem_req", i),    {15'd0, imem_req},    {15'd0, tbl[i].req});
      chk($sformatf("v%0d imem_addr", i),   imem_addr,            tbl[i].addr);
      chk($sformatf("v%0d instr", i),       IF_ID_instr,          tbl[i].instr);
      chk($sformatf("v%0d pc_plus2", i),    IF_ID_pc_plus2,       tbl[i].pp2);
      chk($sformatf("v%0d if_id_valid", i), {15'd0, IF_ID_valid}, {15'd0, tbl[i].iv});
      chk($sformatf("v%0d halted", i),      {15'd0, halted},      {15'd0, tbl[i].halted});
    end

    // HALT word at 0x0040 freezes fetch until a flush.
    halt_en = 1'b1;
    drive(0, 0, 1, 16'h0040, 1);
    drive(0, 0, 0, 16'h0000, 1);
    chk("halt fetch addr", imem_addr, 16'h0040);
    chk("halt fetch req", {15'd0, imem_req}, 16'd1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 16'h0000, 1);
      chk($sformatf("halt%0d halted", i), {15'd0, halted}, 16'd1);
      chk($sformatf("halt%0d req", i), {15'd0, imem_req}, 16'd0);
      chk($sformatf("halt%0d addr", i), imem_addr, 16'h0040);
      chk($sformatf("halt%0d instr", i), IF_ID_instr, 16'hF000);
      chk($sformatf("halt%0d pc_plus2", i), IF_ID_pc_plus2, 16'h0042);
    end
    drive(0, 0, 1, 16'h0050, 0);
    chk("halt flush cycle halted", {15'd0, halted}, 16'd1);
    drive(0, 0, 0, 16'h0000, 1);
    chk("resume halted", {15'd0, halted}, 16'd0);
    chk("resume req", {15'd0, imem_req}, 16'd1);
    chk("resume addr", imem_addr, 16'h0050);
    chk("resume bubble", {15'd0, IF_ID_valid}, 16'd0);
    drive(0, 0, 0, 16'h0000, 1);
    chk("resume instr", IF_ID_instr, tag(16'h0050));
    chk("resume pc_plus2", IF_ID_pc_plus2, 16'h0052);
    chk("resume next addr", imem_addr, 16'h0052);

    // Stall and flush together: flush wins.
    drive(0, 1, 1, 16'h0080, 1);
    chk("sf prior instr", IF_ID_instr, tag(16'h0052));
    drive(0, 0, 0, 16'h0000, 1);
    chk("sf addr", imem_addr, 16'h0080);
    chk("sf bubble valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("sf bubble instr", IF_ID_instr, 16'h0000);

    // PC wrap at 0xFFFE.
    drive(0, 0, 1, 16'hFFFE, 1);
    chk("sf target instr", IF_ID_instr, tag(16'h0080));
    chk("sf target pc_plus2", IF_ID_pc_plus2, 16'h0082);
    drive(0, 0, 0, 16'h0000, 1);
    chk("wrap addr", imem_addr, 16'hFFFE);
    drive(0, 0, 1, 16'h0200, 1);
    chk("wrap instr", IF_ID_instr, tag(16'hFFFE));
    chk("wrap pc_plus2", IF_ID_pc_plus2, 16'h0000);
    chk("wrap valid", {15'd0, IF_ID_valid}, 16'd1);
    chk("wrap next addr", imem_addr, 16'h0000);

    // Reset asserted during a stalled miss.
    drive(0, 0, 0, 16'h0000, 1);
    chk("pre-reset addr", imem_addr, 16'h0200);
    drive(0, 1, 0, 16'h0000, 0);
    chk("miss addr", imem_addr, 16'h0202);
    chk("miss instr held", IF_ID_instr, tag(16'h0200));
    drive(1, 1, 0, 16'h0000, 0);
    chk("rst req low", {15'd0, imem_req}, 16'd0);
    drive(0, 0, 0, 16'h0000, 0);
    chk("post-rst req", {15'd0, imem_req}, 16'd1);
    chk("post-rst addr", imem_addr, 16'h0000);
    chk("post-rst instr", IF_ID_instr, 16'h0000);
    chk("post-rst pc_plus2", IF_ID_pc_plus2, 16'h0000);
    chk("post-rst valid", {15'd0, IF_ID_valid}, 16'd0);
    chk("post-rst halted", {15'd0, halted}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
